lv1_il_ctrl_param: RTL



---
 rtl/lv1_il_pkg.sv | 27 ++
 rtl/lv1_il_tag_match.sv | 68 ++++++
 rtl/lv1_il_ctrl_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lv1_il_pkg.sv
// Shared types and width/address helpers for the level-1 instruction-cache controller.
package lv1_il_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_RESP
  } il_state_e;

  // Storage widths never collapse to zero bits, even for single-entry dimensions.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_width(input int addr_wid, input int sets, input int line_words);
    return addr_wid - $clog2(sets) - $clog2(line_words) - 2;
  endfunction

  function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                             input int width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/lv1_il_tag_match.sv
// Tag/valid storage with parallel compare, first-invalid search and global invalidate.
module lv1_il_tag_match
  import lv1_il_pkg::*;
#(
  parameter  int ASSOC = 4,
  parameter  int SETS  = 64,
  parameter  int TAG_W = 22,
  localparam int WAY_W = $clog2(ASSOC),
  localparam int IDX_W = clog2_min1(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv_all,
  input  logic [IDX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output logic [WAY_W-1:0] hit_way,
  output logic             any_invalid,
  output logic [WAY_W-1:0] first_invalid,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [WAY_W-1:0] clr_way,
  input  logic             wr_en,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag
);

  logic [ASSOC-1:0] valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][ASSOC];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (inv_all) begin
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx][clr_way] <= 1'b0;
      if (wr_en && set_valid) valid_q[wr_idx][wr_way] <= 1'b1;
    end
  end

  // NOTE: tag storage is not reset; the valid bits alone decide whether an entry is meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_idx][wr_way] <= wr_tag;
  end

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit           = 1'b0;
    hit_way       = '0;
    any_invalid   = 1'b0;
    first_invalid = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (!hit && valid_q[lookup_idx][w] && (tag_q[lookup_idx][w] == lookup_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!any_invalid && !valid_q[lookup_idx][w]) begin
        any_invalid   = 1'b1;
        first_invalid = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/lv1_il_ctrl_param.sv
// Level-1 instruction-cache controller: hit service from local arrays, multi-beat line fill
// from level 2 over a request/grant bus, global invalidate with fill poisoning.
module lv1_il_ctrl_param
  import lv1_il_pkg::*;
#(
  parameter int ASSOC      = 4,
  parameter int SETS       = 64,
  parameter int DATA_WID   = 32,
  parameter int ADDR_WID   = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_rd,
  input  logic [ADDR_WID-1:0]      addr_bus_cpu_lv1,
  output logic [DATA_WID-1:0]      data_bus_cpu_lv1,
  output logic                     data_in_bus_cpu_lv1_il,
  output logic                     bus_lv1_lv2_req_proc_il,
  input  logic                     bus_lv1_lv2_gnt_proc,
  output logic                     lv2_rd,
  output logic [ADDR_WID-1:0]      addr_bus_lv1_lv2,
  input  logic [DATA_WID-1:0]      data_bus_lv1_lv2,
  input  logic                     data_in_bus_lv1_lv2,
  input  logic [$clog2(ASSOC)-1:0] lru_replacement_proc,
  output logic [$clog2(ASSOC)-1:0] blk_accessed_main,
  input  logic                     inv_all
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int WAY_W    = $clog2(ASSOC);
  localparam int OFF_W    = clog2_min1(LINE_WORDS);
  localparam int IDX_W    = clog2_min1(SETS);
  localparam int TAG_W    = tag_width(ADDR_WID, SETS, LINE_WORDS);
  localparam int IDX_LSB  = 2 + OFF_BITS;
  localparam int TAG_LSB  = IDX_LSB + IDX_BITS;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  il_state_e state_q, state_d;

  logic [OFF_W-1:0]    cur_off, off_q, beat_cnt_q;
  logic [IDX_W-1:0]    cur_idx, idx_q;
  logic [TAG_W-1:0]    cur_tag, tag_q;
  logic [WAY_W-1:0]    victim_q, out_way_q, hit_way, first_invalid;
  logic [DATA_WID-1:0] resp_data_q;
  logic                hit, any_invalid, hit_q, poison_q, strobe;
  logic                hit_fire, miss_fire, beat_fire, last_beat, abort;

  logic [DATA_WID-1:0] data_q [ASSOC][SETS][LINE_WORDS];

  assign cur_off = OFF_W'(addr_field(64'(addr_bus_cpu_lv1), 2, OFF_BITS));
  assign cur_idx = IDX_W'(addr_field(64'(addr_bus_cpu_lv1), IDX_LSB, IDX_BITS));
  assign cur_tag = TAG_W'(addr_field(64'(addr_bus_cpu_lv1), TAG_LSB, TAG_W));

  lv1_il_tag_match #(
    .ASSOC (ASSOC),
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_tag_match (
    .clk           (clk),
    .rst           (rst),
    .inv_all       (inv_all),
    .lookup_idx    (cur_idx),
    .lookup_tag    (cur_tag),
    .hit           (hit),
    .hit_way       (hit_way),
    .any_invalid   (any_invalid),
    .first_invalid (first_invalid),
    .clr_en        (miss_fire),
    .clr_idx       (cur_idx),
    .clr_way       (any_invalid ? first_invalid : lru_replacement_proc),
    .wr_en         (last_beat),
    .set_valid     (!poison_q),
    .wr_idx        (idx_q),
    .wr_way        (victim_q),
    .wr_tag        (tag_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    hit_fire                = 1'b0;
    miss_fire               = 1'b0;
    beat_fire               = 1'b0;
    last_beat               = 1'b0;
    abort                   = 1'b0;
    bus_lv1_lv2_req_proc_il = 1'b0;
    lv2_rd                  = 1'b0;
    addr_bus_lv1_lv2        = '0;
    unique case (state_q)
      ST_IDLE: begin
        // The strobe cycle of a hit does not look at cpu_rd again.
        if (cpu_rd && !hit_q) begin
          if (hit) begin
            hit_fire = 1'b1;
          end else begin
            miss_fire = 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bus_lv1_lv2_req_proc_il = 1'b1;
        if (bus_lv1_lv2_gnt_proc) state_d = ST_FILL;
      end
      ST_FILL: begin
        bus_lv1_lv2_req_proc_il = 1'b1;
        lv2_rd                  = 1'b1;
        addr_bus_lv1_lv2        = (ADDR_WID'(tag_q) << TAG_LSB) | (ADDR_WID'(idx_q) << IDX_LSB);
        if (!bus_lv1_lv2_gnt_proc) begin
          abort   = 1'b1;
          state_d = ST_REQ;
        end else if (data_in_bus_lv1_lv2) begin
          beat_fire = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            last_beat = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q       <= 1'b0;
      out_way_q   <= '0;
      resp_data_q <= '0;
      victim_q    <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      off_q       <= '0;
      beat_cnt_q  <= '0;
      poison_q    <= 1'b0;
    end else begin
      hit_q <= hit_fire;
      if (hit_fire) begin
        out_way_q   <= hit_way;
        resp_data_q <= data_q[hit_way][cur_idx][cur_off];
      end
      if (miss_fire) begin
        victim_q <= any_invalid ? first_invalid : lru_replacement_proc;
        idx_q    <= cur_idx;
        tag_q    <= cur_tag;
        off_q    <= cur_off;
        poison_q <= 1'b0;
      end
      if (inv_all && (state_q == ST_REQ || state_q == ST_FILL)) poison_q <= 1'b1;
      if (abort) beat_cnt_q <= '0;
      if (beat_fire) begin
        beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
        if (beat_cnt_q == off_q) resp_data_q <= data_bus_lv1_lv2;
      end
      if (last_beat) out_way_q <= victim_q;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_fire) data_q[victim_q][idx_q][beat_cnt_q] <= data_bus_lv1_lv2;
  end

  assign strobe                 = hit_q || (state_q == ST_RESP);
  assign data_in_bus_cpu_lv1_il = strobe;
  assign data_bus_cpu_lv1       = strobe ? resp_data_q : '0;
  assign blk_accessed_main      = strobe ? out_way_q : '0;

endmodule
